// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - control-field encodings shared by the arm_risc_core datapath
package arm_pkg;

  // writeback source select
  localparam logic [1:0] CSRC_DATAIN = 2'd0;
  localparam logic [1:0] CSRC_LIT    = 2'd1;
  localparam logic [1:0] CSRC_MUX    = 2'd2;
  localparam logic [1:0] CSRC_ALU    = 2'd3;

  // PC control
  localparam logic [1:0] CPC_JUMP = 2'd0;
  localparam logic [1:0] CPC_INC  = 2'd1;
  localparam logic [1:0] CPC_SKIP = 2'd2;
  localparam logic [1:0] CPC_HOLD = 2'd3;

  // muxout select; 0-5 pick R0-R5 directly
  localparam logic [2:0] CMSRC_STACK = 3'd6;
  localparam logic [2:0] CMSRC_AMBA  = 3'd7;

  // ALU opcodes (A = R1, B = R2)
  localparam logic [5:0] CALU_PASS = 6'd0;
  localparam logic [5:0] CALU_ADD  = 6'd1;
  localparam logic [5:0] CALU_SUB  = 6'd2;
  localparam logic [5:0] CALU_AND  = 6'd3;
  localparam logic [5:0] CALU_OR   = 6'd4;
  localparam logic [5:0] CALU_XOR  = 6'd5;
  localparam logic [5:0] CALU_NOT  = 6'd6;
  localparam logic [5:0] CALU_INC  = 6'd7;

endpackage

// File: rtl/arm_stack.sv
// rtl/arm_stack.sv - hardware LIFO with push, pop, top, full and empty
module arm_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = $clog2(DEPTH + 1);

  logic [W-1:0]   mem_q [DEPTH];
  logic [SPW-1:0] sp_q;
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  top_idx;

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign wr_idx  = AW'(sp_q);
  assign top_idx = AW'(sp_q - SPW'(1));
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  // pointer and entries; pop wins over push, overflow/underflow are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (pop_i) begin
      if (!empty_o) sp_q <= sp_q - SPW'(1);
    end else if (push_i && !full_o) begin
      mem_q[wr_idx] <= din_i;
      sp_q          <= sp_q + SPW'(1);
    end
  end

endmodule

// File: rtl/arm_risc_core.sv
// rtl/arm_risc_core.sv - 8-bit single-cycle RISC datapath driven by external decoded controls
module arm_risc_core
  import arm_pkg::*;
#(
  parameter int         STACK_DEPTH = 8,
  parameter logic [7:0] INT_VECTOR  = 8'hF0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       eint,
  input  logic [7:0] Literal,
  input  logic [5:0] Addr,
  input  logic [7:0] datain,
  input  logic [7:0] ambain,
  input  logic       wr_en,
  input  logic [5:0] calu,
  input  logic [1:0] cpc,
  input  logic [1:0] csrc,
  input  logic [2:0] cmsrc,
  input  logic       cal,
  input  logic       ret,
  input  logic       push,
  input  logic       pop,
  output logic [7:0] dataout,
  output logic [7:0] R0,
  output logic [7:0] R1,
  output logic [7:0] R2,
  output logic [7:0] R3,
  output logic [7:0] R4,
  output logic [7:0] R5,
  output logic [7:0] R6,
  output logic [7:0] PC,
  output logic [7:0] muxout,
  output logic [7:0] CEE,
  output logic       CEENZ,
  output logic [7:0] LNK,
  output logic [7:0] stack
);

  logic [7:0] rf_q [8];
  logic [7:0] pc_q, pc_d;
  logic [7:0] lnk_q, lnk_d;
  logic [7:0] alu_y, wb;
  logic [7:0] stk_top;
  logic       stk_full, stk_empty, stk_push, stk_pop;

  // pop takes precedence; the stack also guards, this keeps the intent visible here
  assign stk_pop  = pop & ~stk_empty;
  assign stk_push = push & ~pop & ~stk_full;

  arm_stack #(.DEPTH(STACK_DEPTH), .W(8)) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .din_i   (muxout),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  assign stack   = stk_empty ? 8'h00 : stk_top;
  assign CEE     = rf_q[0] ^ Literal;
  assign CEENZ   = |CEE;
  assign PC      = pc_q;
  assign LNK     = lnk_q;
  assign R0      = rf_q[0];
  assign R1      = rf_q[1];
  assign R2      = rf_q[2];
  assign R3      = rf_q[3];
  assign R4      = rf_q[4];
  assign R5      = rf_q[5];
  assign R6      = rf_q[6];
  assign dataout = rf_q[7];

  // ALU on fixed operands R1/R2; undefined opcodes fall back to R0
  always_comb begin
    alu_y = rf_q[0];
    case (calu)
      CALU_PASS: alu_y = rf_q[0];
      CALU_ADD:  alu_y = rf_q[1] + rf_q[2];
      CALU_SUB:  alu_y = rf_q[1] - rf_q[2];
      CALU_AND:  alu_y = rf_q[1] & rf_q[2];
      CALU_OR:   alu_y = rf_q[1] | rf_q[2];
      CALU_XOR:  alu_y = rf_q[1] ^ rf_q[2];
      CALU_NOT:  alu_y = ~rf_q[1];
      CALU_INC:  alu_y = rf_q[1] + 8'd1;
      default:   alu_y = rf_q[0];
    endcase
  end

  // muxout: registers R0-R5, stack top, or the bus input
  always_comb begin
    muxout = rf_q[cmsrc];
    case (cmsrc)
      CMSRC_STACK: muxout = stack;
      CMSRC_AMBA:  muxout = ambain;
      default:     muxout = rf_q[cmsrc];
    endcase
  end

  // writeback source select
  always_comb begin
    wb = datain;
    case (csrc)
      CSRC_DATAIN: wb = datain;
      CSRC_LIT:    wb = Literal;
      CSRC_MUX:    wb = muxout;
      CSRC_ALU:    wb = alu_y;
      default:     wb = datain;
    endcase
  end

  // PC / link next state: interrupt, then return, then call, then cpc
  always_comb begin
    pc_d  = pc_q;
    lnk_d = lnk_q;
    if (eint) begin
      lnk_d = pc_q;
      pc_d  = INT_VECTOR;
    end else if (ret) begin
      pc_d = lnk_q;
    end else if (cal) begin
      lnk_d = pc_q + 8'd1;
      pc_d  = Literal;
    end else begin
      case (cpc)
        CPC_JUMP: pc_d = Literal;
        CPC_INC:  pc_d = pc_q + 8'd1;
        CPC_SKIP: pc_d = pc_q + (CEENZ ? 8'd2 : 8'd1);
        CPC_HOLD: pc_d = pc_q;
        default:  pc_d = pc_q;
      endcase
    end
  end

  // register file, PC and link register; addresses 8-63 never write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= 8'h00;
      pc_q  <= 8'h00;
      lnk_q <= 8'h00;
    end else begin
      if (wr_en && (Addr < 6'd8)) rf_q[Addr[2:0]] <= wb;
      pc_q  <= pc_d;
      lnk_q <= lnk_d;
    end
  end

endmodule

// File: tb/tb_arm_risc_core.sv
// tb/tb_arm_risc_core.sv - directed vector bench for arm_risc_core
module tb_arm_risc_core;

  logic       clk = 1'b0;
  logic       rst, eint, wr_en, cal, ret, push, pop;
  logic [7:0] Literal, datain, ambain;
  logic [5:0] Addr, calu;
  logic [1:0] cpc, csrc;
  logic [2:0] cmsrc;
  logic [7:0] dataout, R0, R1, R2, R3, R4, R5, R6, PC, muxout, CEE, LNK, stack;
  logic       CEENZ;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arm_risc_core dut (
    .clk(clk), .rst(rst), .eint(eint), .Literal(Literal), .Addr(Addr),
    .datain(datain), .ambain(ambain), .wr_en(wr_en), .calu(calu), .cpc(cpc),
    .csrc(csrc), .cmsrc(cmsrc), .cal(cal), .ret(ret), .push(push), .pop(pop),
    .dataout(dataout), .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5),
    .R6(R6), .PC(PC), .muxout(muxout), .CEE(CEE), .CEENZ(CEENZ), .LNK(LNK),
    .stack(stack)
  );

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [1:0] csrc;
    logic [2:0] cmsrc;
    logic [5:0] calu;
    logic [1:0] cpc;
    logic [7:0] lit;
    logic [7:0] din;
    logic       push, pop, cal, ret, eint;
    logic [7:0] e_cee;
    logic [7:0] e_pc, e_r0, e_r1, e_r2, e_lnk, e_stk;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(
    input logic wr, input logic [5:0] addr, input logic [1:0] cs, input logic [2:0] cm,
    input logic [5:0] ca, input logic [1:0] cp, input logic [7:0] lit, input logic [7:0] din,
    input logic pu, input logic po, input logic cl, input logic rt, input logic ei,
    input logic [7:0] ecee, input logic [7:0] epc, input logic [7:0] er0,
    input logic [7:0] er1, input logic [7:0] er2, input logic [7:0] elnk, input logic [7:0] estk);
    vec_t v;
    v.wr = wr; v.addr = addr; v.csrc = cs; v.cmsrc = cm; v.calu = ca; v.cpc = cp;
    v.lit = lit; v.din = din; v.push = pu; v.pop = po; v.cal = cl; v.ret = rt; v.eint = ei;
    v.e_cee = ecee; v.e_pc = epc; v.e_r0 = er0; v.e_r1 = er1; v.e_r2 = er2;
    v.e_lnk = elnk; v.e_stk = estk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic idle();
    eint = 0; wr_en = 0; cal = 0; ret = 0; push = 0; pop = 0;
    Literal = 8'h00; datain = 8'h00; ambain = 8'h00; Addr = 6'd0;
    calu = 6'd0; cpc = 2'd1; csrc = 2'd0; cmsrc = 3'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // wr addr cs cm calu cpc lit din  pu po cl rt ei  cee   pc     r0     r1     r2     lnk    stk
    vecs[0]  = mk(1, 1, 0, 0, 0, 1, 8'h00, 8'h11, 0,0,0,0,0, 8'h00, 8'h01, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00);
    vecs[1]  = mk(1, 2, 1, 0, 0, 1, 8'h2B, 8'h00, 0,0,0,0,0, 8'h2B, 8'h02, 8'h00, 8'h11, 8'h2B, 8'h00, 8'h00);
    vecs[2]  = mk(1, 0, 3, 0, 1, 1, 8'h00, 8'h00, 0,0,0,0,0, 8'h00, 8'h03, 8'h3C, 8'h11, 8'h2B, 8'h00, 8'h00);
    vecs[3]  = mk(0, 0, 0, 0, 0, 2, 8'h3C, 8'h00, 0,0,0,0,0, 8'h00, 8'h04, 8'h3C, 8'h11, 8'h2B, 8'h00, 8'h00);
    vecs[4]  = mk(0, 0, 0, 0, 0, 2, 8'h30, 8'h00, 0,0,0,0,0, 8'h0C, 8'h06, 8'h3C, 8'h11, 8'h2B, 8'h00, 8'h00);
    vecs[5]  = mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 1,0,0,0,0, 8'h3C, 8'h07, 8'h3C, 8'h11, 8'h2B, 8'h00, 8'h3C);
    vecs[6]  = mk(1, 0, 0, 0, 0, 1, 8'h00, 8'h11, 0,0,0,0,0, 8'h3C, 8'h08, 8'h11, 8'h11, 8'h2B, 8'h00, 8'h3C);
    vecs[7]  = mk(1, 0, 2, 6, 0, 1, 8'h00, 8'h00, 0,1,0,0,0, 8'h11, 8'h09, 8'h3C, 8'h11, 8'h2B, 8'h00, 8'h00);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0,1,0,0,0, 8'h3C, 8'h0A, 8'h3C, 8'h11, 8'h2B, 8'h00, 8'h00);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 8'hA2, 8'h00, 0,0,0,0,0, 8'h9E, 8'hA2, 8'h3C, 8'h11, 8'h2B, 8'h00, 8'h00);
    vecs[10] = mk(0, 0, 0, 0, 0, 1, 8'hAA, 8'h00, 0,0,1,0,0, 8'h96, 8'hAA, 8'h3C, 8'h11, 8'h2B, 8'hA3, 8'h00);
    vecs[11] = mk(1,12, 1, 0, 0, 1, 8'hFF, 8'h00, 0,0,0,0,0, 8'hC3, 8'hAB, 8'h3C, 8'h11, 8'h2B, 8'hA3, 8'h00);
    vecs[12] = mk(1,19, 1, 0, 0, 1, 8'hEE, 8'h00, 0,0,0,0,0, 8'hD2, 8'hAC, 8'h3C, 8'h11, 8'h2B, 8'hA3, 8'h00);
    vecs[13] = mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0,0,0,1,0, 8'h3C, 8'hA3, 8'h3C, 8'h11, 8'h2B, 8'hA3, 8'h00);
    vecs[14] = mk(1, 0, 3, 0, 2, 1, 8'h00, 8'h00, 0,0,0,0,0, 8'h3C, 8'hA4, 8'hE6, 8'h11, 8'h2B, 8'hA3, 8'h00);
    vecs[15] = mk(1, 0, 3, 0, 3, 1, 8'h00, 8'h00, 0,0,0,0,0, 8'hE6, 8'hA5, 8'h01, 8'h11, 8'h2B, 8'hA3, 8'h00);
    vecs[16] = mk(1, 0, 3, 0, 4, 1, 8'h00, 8'h00, 0,0,0,0,0, 8'h01, 8'hA6, 8'h3B, 8'h11, 8'h2B, 8'hA3, 8'h00);
    vecs[17] = mk(1, 0, 3, 0, 5, 1, 8'h00, 8'h00, 0,0,0,0,0, 8'h3B, 8'hA7, 8'h3A, 8'h11, 8'h2B, 8'hA3, 8'h00);
    vecs[18] = mk(1, 0, 3, 0, 6, 1, 8'h00, 8'h00, 0,0,0,0,0, 8'h3A, 8'hA8, 8'hEE, 8'h11, 8'h2B, 8'hA3, 8'h00);
    vecs[19] = mk(1, 0, 3, 0, 7, 1, 8'h00, 8'h00, 0,0,0,0,0, 8'hEE, 8'hA9, 8'h12, 8'h11, 8'h2B, 8'hA3, 8'h00);
    vecs[20] = mk(1, 0, 3, 0, 9, 1, 8'h00, 8'h00, 0,0,0,0,0, 8'h12, 8'hAA, 8'h12, 8'h11, 8'h2B, 8'hA3, 8'h00);
    vecs[21] = mk(1, 0, 3, 0, 0, 1, 8'h00, 8'h00, 0,0,0,0,0, 8'h12, 8'hAB, 8'h12, 8'h11, 8'h2B, 8'hA3, 8'h00);
    vecs[22] = mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0,0,1,1,1, 8'h12, 8'hF0, 8'h12, 8'h11, 8'h2B, 8'hAB, 8'h00);
    vecs[23] = mk(0, 0, 0, 0, 0, 1, 8'h55, 8'h00, 0,0,1,1,0, 8'h47, 8'hAB, 8'h12, 8'h11, 8'h2B, 8'hAB, 8'h00);
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 8'h40, 8'h00, 0,0,1,0,0, 8'h52, 8'h40, 8'h12, 8'h11, 8'h2B, 8'hAC, 8'h00);
    vecs[25] = mk(0, 0, 0, 0, 0, 3, 8'h00, 8'h00, 0,0,0,0,0, 8'h12, 8'h40, 8'h12, 8'h11, 8'h2B, 8'hAC, 8'h00);

    // reset
    idle();
    rst = 1;
    tick();
    rst = 0;
    chk("rst.pc", PC, 8'h00);
    chk("rst.r0", R0, 8'h00);
    chk("rst.r1", R1, 8'h00);
    chk("rst.r2", R2, 8'h00);
    chk("rst.r3", R3, 8'h00);
    chk("rst.r4", R4, 8'h00);
    chk("rst.r5", R5, 8'h00);
    chk("rst.r6", R6, 8'h00);
    chk("rst.lnk", LNK, 8'h00);
    chk("rst.stack", stack, 8'h00);
    chk("rst.dataout", dataout, 8'h00);
    chk("rst.ceenz", {7'd0, CEENZ}, 8'h00);

    // table-driven program
    for (int i = 0; i < 26; i++) begin
      wr_en = vecs[i].wr; Addr = vecs[i].addr; csrc = vecs[i].csrc; cmsrc = vecs[i].cmsrc;
      calu = vecs[i].calu; cpc = vecs[i].cpc; Literal = vecs[i].lit; datain = vecs[i].din;
      push = vecs[i].push; pop = vecs[i].pop; cal = vecs[i].cal; ret = vecs[i].ret;
      eint = vecs[i].eint;
      #1;
      chk($sformatf("v%0d.cee", i), CEE, vecs[i].e_cee);
      chk($sformatf("v%0d.ceenz", i), {7'd0, CEENZ}, {7'd0, vecs[i].e_cee != 8'h00});
      tick();
      chk($sformatf("v%0d.pc", i), PC, vecs[i].e_pc);
      chk($sformatf("v%0d.r0", i), R0, vecs[i].e_r0);
      chk($sformatf("v%0d.r1", i), R1, vecs[i].e_r1);
      chk($sformatf("v%0d.r2", i), R2, vecs[i].e_r2);
      chk($sformatf("v%0d.lnk", i), LNK, vecs[i].e_lnk);
      chk($sformatf("v%0d.stack", i), stack, vecs[i].e_stk);
      idle();
    end

    // out-of-range addresses must not have aliased onto R3-R7
    chk("noalias.r3", R3, 8'h00);
    chk("noalias.r4", R4, 8'h00);
    chk("noalias.r5", R5, 8'h00);
    chk("noalias.r6", R6, 8'h00);
    chk("noalias.r7", dataout, 8'h00);

    // LOAD R3 0x5A, then MOV R7,R3
    wr_en = 1; Addr = 6'd3; csrc = 2'd1; Literal = 8'h5A;
    tick();
    idle();
    wr_en = 1; Addr = 6'd7; csrc = 2'd2; cmsrc = 3'd3;
    #1;
    chk("mov.muxout", muxout, 8'h5A);
    tick();
    idle();
    chk("mov.dataout", dataout, 8'h5A);
    chk("mov.r3", R3, 8'h5A);

    // fill the stack from the bus, then one extra push that must be dropped
    for (int i = 0; i < 9; i++) begin
      push = 1; cmsrc = 3'd7; ambain = 8'h80 + 8'(i);
      tick();
      idle();
      chk($sformatf("fill%0d.stack", i), stack, (i < 8) ? 8'h80 + 8'(i) : 8'h87);
    end

    // push and pop together: pop wins
    push = 1; pop = 1; cmsrc = 3'd7; ambain = 8'h99;
    tick();
    idle();
    chk("pushpop.stack", stack, 8'h86);

    // drain: 7 entries remain (0x80..0x86)
    for (int j = 1; j <= 7; j++) begin
      pop = 1;
      tick();
      idle();
      chk($sformatf("drain%0d.stack", j), stack, (j < 7) ? 8'h86 - 8'(j) : 8'h00);
    end

    // PC wrap on compare-skip: R0=0x12, Literal=0 -> CEENZ=1, 0xFE+2 wraps to 0
    cpc = 2'd0; Literal = 8'hFE;
    tick();
    idle();
    chk("wrap.jmp", PC, 8'hFE);
    cpc = 2'd2; Literal = 8'h00;
    tick();
    idle();
    chk("wrap.pc", PC, 8'h00);

    // reset overrides every other strobe
    rst = 1; wr_en = 1; Addr = 6'd0; csrc = 2'd1; Literal = 8'h77;
    push = 1; cmsrc = 3'd7; ambain = 8'h44; cal = 1; eint = 1;
    tick();
    rst = 0;
    idle();
    chk("rst2.pc", PC, 8'h00);
    chk("rst2.r0", R0, 8'h00);
    chk("rst2.r3", R3, 8'h00);
    chk("rst2.lnk", LNK, 8'h00);
    chk("rst2.stack", stack, 8'h00);
    chk("rst2.dataout", dataout, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
